// File: rtl/oled_pkg.sv
// ============================================================================
// Module : oled_pkg
// Brief  : Shared geometry, colour type and sprite attribute record for the
//          96x64 OLED sprite compositor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package oled_pkg;

    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t OLED_BG          = 16'h0000;
    localparam rgb565_t OLED_TRANSPARENT = 16'hF81F;

    typedef struct packed {
        logic [6:0] x;
        logic [5:0] y;
        logic       vis;
        logic       flip;
    } sprite_attr_t;

endpackage

`default_nettype wire

// File: rtl/sprite_hit_unit.sv
// ============================================================================
// Module : sprite_hit_unit
// Brief  : One sprite channel: double-buffered attributes plus the stage-1
//          bounding-box test and ROM address generation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sprite_hit_unit
    import oled_pkg::*;
#(
    parameter  int SPR_W = 16,
    parameter  int SPR_H = 16,
    localparam int CW    = $clog2(SPR_W),
    localparam int RW    = $clog2(SPR_H)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_frame_begin,
    input  logic            i_wr_en,
    input  sprite_attr_t    i_wr_attr,
    input  logic            i_valid,
    input  logic [6:0]      i_x,
    input  logic [5:0]      i_y,
    output logic            o_hit,
    output logic [RW+CW-1:0] o_addr
);

    localparam logic [7:0] c_W8 = 8'(SPR_W);
    localparam logic [7:0] c_H8 = 8'(SPR_H);

    sprite_attr_t    r_shadow;
    sprite_attr_t    r_active;
    logic            r_hit;
    logic [RW+CW-1:0] r_addr;

    logic [7:0]      w_x8, w_sx8, w_y8, w_sy8;
    logic [CW-1:0]   w_col_raw;
    logic [CW-1:0]   w_col;
    logic [RW-1:0]   w_row;
    logic            w_hit;

    // 8-bit compares keep sx+SPR_W from wrapping when the sprite sits near x=127
    always_comb begin
        w_x8      = {1'b0, i_x};
        w_sx8     = {1'b0, r_active.x};
        w_y8      = {2'b00, i_y};
        w_sy8     = {2'b00, r_active.y};
        w_hit     = i_valid && r_active.vis &&
                    (w_x8 >= w_sx8) && (w_x8 < w_sx8 + c_W8) &&
                    (w_y8 >= w_sy8) && (w_y8 < w_sy8 + c_H8);
        w_col_raw = CW'(w_x8 - w_sx8);
        // SPR_W is a power of two, so SPR_W-1-col is a bitwise inversion
        w_col     = r_active.flip ? ~w_col_raw : w_col_raw;
        w_row     = RW'(w_y8 - w_sy8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_hit    <= 1'b0;
            r_addr   <= '0;
        end else begin
            if (i_wr_en) begin
                r_shadow <= i_wr_attr;
            end
            if (i_frame_begin) begin
                r_active <= i_wr_en ? i_wr_attr : r_shadow;
            end
            r_hit  <= w_hit;
            r_addr <= {w_row, w_col};
        end
    end

    assign o_hit  = r_hit;
    assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/oled_sprite_compositor.sv
// ============================================================================
// Module : oled_sprite_compositor
// Brief  : Two-stage pixel pipeline compositing prioritised sprites over a
//          background colour, with per-frame sprite0/sprite1 hit detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module oled_sprite_compositor
    import oled_pkg::*;
#(
    parameter  int      WIDTH       = OLED_W,
    parameter  int      HEIGHT      = OLED_H,
    parameter  int      NUM_SPRITES = 4,
    parameter  int      SPR_W       = 16,
    parameter  int      SPR_H       = 16,
    parameter  rgb565_t BG_COLOUR   = OLED_BG,
    parameter  rgb565_t TRANSPARENT = OLED_TRANSPARENT,
    localparam int      SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int      ASPR        = $clog2(SPR_W * SPR_H)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_begin,
    input  logic [12:0]                 pixel_index,
    input  logic                        wr_en,
    input  logic [SEL_W-1:0]            wr_sel,
    input  logic [6:0]                  wr_x,
    input  logic [5:0]                  wr_y,
    input  logic                        wr_vis,
    input  logic                        wr_flip,
    output logic [NUM_SPRITES*ASPR-1:0] spr_addr,
    input  logic [NUM_SPRITES*16-1:0]   spr_data,
    output logic [15:0]                 pixel_data,
    output logic                        collide
);

    localparam int c_PIX_TOTAL = WIDTH * HEIGHT;

    logic [31:0]            w_idx32;
    logic [31:0]            w_row_base;
    logic                   w_in_range;
    logic [6:0]             w_x_col;
    logic [5:0]             w_y_row;
    sprite_attr_t           w_wr_attr;

    logic [NUM_SPRITES-1:0] w_hit;
    logic [NUM_SPRITES-1:0] w_opaque;
    rgb565_t                w_pixel;
    logic                   w_overlap;

    rgb565_t                r_pixel;
    logic                   r_acc;
    logic                   r_collide;

    assign w_idx32    = 32'(pixel_index);
    assign w_in_range = (w_idx32 < 32'(c_PIX_TOTAL));
    assign w_wr_attr  = '{x: wr_x, y: wr_y, vis: wr_vis, flip: wr_flip};

    // Row found by comparing against constant row starts, avoiding a divider
    always_comb begin
        w_y_row    = '0;
        w_row_base = '0;
        for (int r = 1; r < HEIGHT; r++) begin
            if (w_idx32 >= 32'(r * WIDTH)) begin
                w_y_row    = 6'(r);
                w_row_base = 32'(r * WIDTH);
            end
        end
    end

    assign w_x_col = 7'(w_idx32 - w_row_base);

    generate
        for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
            logic w_wr_this;
            assign w_wr_this = wr_en && (int'(wr_sel) == g);

            sprite_hit_unit #(
                .SPR_W (SPR_W),
                .SPR_H (SPR_H)
            ) u_hit (
                .clk           (clk),
                .rst           (reset),
                .i_frame_begin (frame_begin),
                .i_wr_en       (w_wr_this),
                .i_wr_attr     (w_wr_attr),
                .i_valid       (w_in_range),
                .i_x           (w_x_col),
                .i_y           (w_y_row),
                .o_hit         (w_hit[g]),
                .o_addr        (spr_addr[g*ASPR +: ASPR])
            );
        end
    endgenerate

    // Highest index first so the lowest-index opaque sprite wins
    always_comb begin
        w_opaque = '0;
        w_pixel  = BG_COLOUR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            w_opaque[i] = w_hit[i] && (spr_data[i*16 +: 16] != TRANSPARENT);
            if (w_opaque[i]) begin
                w_pixel = spr_data[i*16 +: 16];
            end
        end
        w_overlap = w_opaque[0] && w_opaque[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel   <= BG_COLOUR;
            r_acc     <= 1'b0;
            r_collide <= 1'b0;
        end else begin
            r_pixel <= w_pixel;
            if (frame_begin) begin
                r_collide <= r_acc;
                r_acc     <= w_overlap;
            end else begin
                r_acc <= r_acc | w_overlap;
            end
        end
    end

    assign pixel_data = r_pixel;
    assign collide    = r_collide;

endmodule

`default_nettype wire

// File: tb/tb_oled_sprite_compositor.sv
// ============================================================================
// Module : tb_oled_sprite_compositor
// Brief  : Self-checking bench for oled_sprite_compositor with a per-pixel
//          reference model and behavioural sprite ROMs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_oled_sprite_compositor;

    localparam int          N   = 4;
    localparam int          W   = 96;
    localparam int          H   = 64;
    localparam int          OOR = 6200;
    localparam logic [15:0] BG  = 16'h0000;
    localparam logic [15:0] TR  = 16'hF81F;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_begin;
    logic [12:0]   pixel_index;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [6:0]    wr_x;
    logic [5:0]    wr_y;
    logic          wr_vis;
    logic          wr_flip;
    logic [N*8-1:0]  spr_addr;
    logic [N*16-1:0] spr_data;
    logic [15:0]   pixel_data;
    logic          collide;

    always #5 clk = ~clk;

    oled_sprite_compositor dut (
        .clk         (clk),
        .reset       (reset),
        .frame_begin (frame_begin),
        .pixel_index (pixel_index),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_vis      (wr_vis),
        .wr_flip     (wr_flip),
        .spr_addr    (spr_addr),
        .spr_data    (spr_data),
        .pixel_data  (pixel_data),
        .collide     (collide)
    );

    logic [15:0] rom [N][256];

    always_comb begin
        spr_data = '0;
        for (int s = 0; s < N; s++) begin
            spr_data[s*16 +: 16] = rom[s][spr_addr[s*8 +: 8]];
        end
    end

    // Reference state
    int          sh_x [N], sh_y [N], ac_x [N], ac_y [N];
    bit          sh_vis [N], sh_flip [N], ac_vis [N], ac_flip [N];
    logic [15:0] m_pix_d1, exp_pix;
    bit          m_ov_d1, m_acc, exp_col;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void model_eval(input int idx, output logic [15:0] p, output bit ov);
        bit          op [N];
        logic [15:0] d [N];
        int          x, y, col, row;
        p  = BG;
        ov = 1'b0;
        if (idx >= W * H) return;
        x = idx % W;
        y = idx / W;
        for (int s = 0; s < N; s++) begin
            op[s] = 1'b0;
            d[s]  = '0;
            if (ac_vis[s] && x >= ac_x[s] && x < ac_x[s] + 16 && y >= ac_y[s] && y < ac_y[s] + 16) begin
                col = x - ac_x[s];
                if (ac_flip[s]) col = 15 - col;
                row   = y - ac_y[s];
                d[s]  = rom[s][row * 16 + col];
                op[s] = (d[s] != TR);
            end
        end
        for (int s = N - 1; s >= 0; s--) if (op[s]) p = d[s];
        ov = op[0] && op[1];
    endfunction

    task automatic step(input int idx, input bit fb = 0, input bit we = 0, input int sel = 0,
                        input int ax = 0, input int ay = 0, input bit av = 0, input bit af = 0);
        logic [15:0] p;
        bit          ov;
        pixel_index = 13'(idx);
        frame_begin = fb;
        wr_en       = we;
        wr_sel      = 2'(sel);
        wr_x        = 7'(ax);
        wr_y        = 6'(ay);
        wr_vis      = av;
        wr_flip     = af;
        model_eval(idx, p, ov);
        @(posedge clk);
        exp_pix  = m_pix_d1;
        m_pix_d1 = p;
        if (fb) begin
            exp_col = m_acc;
            m_acc   = m_ov_d1;
        end else begin
            m_acc = m_acc | m_ov_d1;
        end
        m_ov_d1 = ov;
        if (we) begin
            sh_x[sel] = ax; sh_y[sel] = ay; sh_vis[sel] = av; sh_flip[sel] = af;
        end
        if (fb) begin
            for (int s = 0; s < N; s++) begin
                ac_x[s] = sh_x[s]; ac_y[s] = sh_y[s]; ac_vis[s] = sh_vis[s]; ac_flip[s] = sh_flip[s];
            end
        end
        #1;
        frame_begin = 1'b0;
        wr_en       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(OOR);
    endtask

    task automatic fill_rom(input int s, input logic [15:0] v);
        for (int a = 0; a < 256; a++) rom[s][a] = v;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        pixel_index = '0;
        frame_begin = 1'b0;
        wr_en       = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < N; s++) begin
            sh_x[s] = 0; sh_y[s] = 0; sh_vis[s] = 0; sh_flip[s] = 0;
            ac_x[s] = 0; ac_y[s] = 0; ac_vis[s] = 0; ac_flip[s] = 0;
        end
        m_pix_d1 = BG; exp_pix = BG; m_ov_d1 = 0; m_acc = 0; exp_col = 0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < N; s++) fill_rom(s, 16'h1111 * 16'(s + 1));
        reset_dut();
        step(OOR, 0, 1, 0, 0, 0, 1, 0);
        step(OOR, 1);
        step(5);
        reset_dut();
        n_checks++;
        if (pixel_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_pixel got %h want 0000", pixel_data);
        end
        n_checks++;
        if (collide !== 1'b0) begin
            n_fail++; $display("FAIL reset_collide got %b want 0", collide);
        end
        step(5);
        step(OOR);
        n_checks++;
        if (pixel_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_attr_clear got %h want 0000", pixel_data);
        end
    endtask

    task automatic test_blank_sweep();
        for (int i = 0; i < W * H + 2; i++) begin
            step((i < W * H) ? i : OOR);
            n_checks++;
            if (pixel_data !== 16'h0000) begin
                n_fail++; $display("FAIL blank_sweep i=%0d got %h want 0000", i, pixel_data);
            end
        end
        n_checks++;
        if (collide !== 1'b0) begin
            n_fail++; $display("FAIL blank_collide got %b want 0", collide);
        end
    endtask

    task automatic test_single_sprite();
        int          idx_t [6] = '{20*96+10, 20*96+26, 20*96+25, 19*96+10, 35*96+10, 36*96+10};
        logic [15:0] exp_t [6] = '{16'h07E0, 16'h0000, 16'h07E0, 16'h0000, 16'h07E0, 16'h0000};
        idle(2);
        fill_rom(0, 16'h07E0);
        step(OOR, 0, 1, 0, 10, 20, 1, 0);
        step(OOR, 1);
        for (int k = 0; k < 6; k++) begin
            step(idx_t[k]);
            n_checks++;
            if (pixel_data !== exp_pix) begin
                n_fail++; $display("FAIL single_latency k=%0d got %h want %h", k, pixel_data, exp_pix);
            end
            step(OOR);
            n_checks++;
            if (pixel_data !== exp_t[k]) begin
                n_fail++; $display("FAIL single_pixel idx=%0d got %h want %h", idx_t[k], pixel_data, exp_t[k]);
            end
        end
    endtask

    task automatic test_collision();
        idle(2);
        fill_rom(0, 16'hF800);
        fill_rom(1, 16'h001F);
        step(OOR, 0, 1, 0, 40, 30, 1, 0);
        step(OOR, 0, 1, 1, 40, 30, 1, 0);
        step(OOR, 1);
        for (int i = 0; i < W * H; i++) begin
            step(i);
            n_checks++;
            if (pixel_data !== exp_pix) begin
                n_fail++; $display("FAIL overlap_frame i=%0d got %h want %h", i, pixel_data, exp_pix);
            end
        end
        step(OOR, 1);
        n_checks++;
        if (collide !== 1'b1) begin
            n_fail++; $display("FAIL collide_set got %b want 1", collide);
        end
        step(35*96+45);
        step(OOR);
        n_checks++;
        if (pixel_data !== 16'hF800) begin
            n_fail++; $display("FAIL overlap_priority got %h want F800", pixel_data);
        end
        step(OOR, 0, 1, 1, 80, 0, 1, 0);
        step(OOR, 1);
        for (int i = 0; i < W * H; i++) begin
            step(i);
            n_checks++;
            if (pixel_data !== exp_pix || collide !== exp_col) begin
                n_fail++; $display("FAIL moved_frame i=%0d got %h/%b want %h/%b", i, pixel_data, collide, exp_pix, exp_col);
            end
        end
        n_checks++;
        if (collide !== 1'b1) begin
            n_fail++; $display("FAIL collide_hold got %b want 1", collide);
        end
        step(OOR, 1);
        n_checks++;
        if (collide !== 1'b0) begin
            n_fail++; $display("FAIL collide_clear got %b want 0", collide);
        end
    endtask

    task automatic test_double_buffer();
        idle(2);
        fill_rom(2, 16'h1234);
        step(OOR, 0, 1, 0, 0, 0, 0, 0);
        step(OOR, 0, 1, 1, 0, 0, 0, 0);
        step(OOR, 0, 1, 2, 0, 0, 1, 0);
        step(OOR, 1);
        for (int i = 0; i < 2000; i++) begin
            if (i == 100) step(i, 0, 1, 2, 50, 40, 1, 0);
            else          step(i);
            n_checks++;
            if (pixel_data !== exp_pix) begin
                n_fail++; $display("FAIL midframe_write i=%0d got %h want %h", i, pixel_data, exp_pix);
            end
        end
        step(0); step(OOR);
        n_checks++;
        if (pixel_data !== 16'h1234) begin
            n_fail++; $display("FAIL shadow_old_pos got %h want 1234", pixel_data);
        end
        step(40*96+50); step(OOR);
        n_checks++;
        if (pixel_data !== 16'h0000) begin
            n_fail++; $display("FAIL shadow_new_pos got %h want 0000", pixel_data);
        end
        step(OOR, 1, 1, 2, 70, 10, 1, 0);
        step(10*96+70); step(OOR);
        n_checks++;
        if (pixel_data !== 16'h1234) begin
            n_fail++; $display("FAIL coincident_write got %h want 1234", pixel_data);
        end
        step(0); step(OOR);
        n_checks++;
        if (pixel_data !== 16'h0000) begin
            n_fail++; $display("FAIL coincident_old_pos got %h want 0000", pixel_data);
        end
    endtask

    task automatic test_flip_transparency();
        int          idx_t [3] = '{5*96+35, 5*96+20, 5*96+21};
        logic [15:0] e1 [3]    = '{16'hFFFF, 16'h4208, 16'h0000};
        logic [15:0] e2 [3]    = '{16'hFFFF, 16'h00FF, 16'h0000};
        idle(2);
        for (int a = 0; a < 256; a++)
            rom[3][a] = (a % 16 == 0) ? 16'hFFFF : ((a % 16 == 14) ? TR : 16'h4208);
        step(OOR, 0, 1, 3, 20, 5, 1, 1);
        step(OOR, 1);
        for (int k = 0; k < 3; k++) begin
            step(idx_t[k]); step(OOR);
            n_checks++;
            if (pixel_data !== e1[k]) begin
                n_fail++; $display("FAIL flip_pixel k=%0d got %h want %h", k, pixel_data, e1[k]);
            end
        end
        fill_rom(2, TR);
        rom[2][0] = 16'h00FF;
        step(OOR, 1, 1, 2, 20, 5, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(idx_t[k]); step(OOR);
            n_checks++;
            if (pixel_data !== e2[k]) begin
                n_fail++; $display("FAIL transparent_stack k=%0d got %h want %h", k, pixel_data, e2[k]);
            end
        end
    endtask

    task automatic test_clip_range();
        int          idx_t [9] = '{90, 91, 92, 93, 94, 95, 96, 96+90, 6143};
        idle(2);
        fill_rom(0, 16'hAAAA);
        fill_rom(1, 16'h5555);
        step(OOR, 0, 1, 2, 0, 0, 0, 0);
        step(OOR, 0, 1, 3, 0, 0, 0, 0);
        step(OOR, 0, 1, 0, 90, 0, 1, 0);
        step(OOR, 0, 1, 1, 90, 0, 1, 0);
        step(OOR, 1);
        idle(20);
        n_checks++;
        if (pixel_data !== 16'h0000) begin
            n_fail++; $display("FAIL out_of_range_pixel got %h want 0000", pixel_data);
        end
        step(OOR, 1);
        n_checks++;
        if (collide !== 1'b0) begin
            n_fail++; $display("FAIL out_of_range_collide got %b want 0", collide);
        end
        for (int k = 0; k < 9; k++) begin
            step(idx_t[k]); step(OOR);
            n_checks++;
            if (pixel_data !== ((k < 6 || k == 7) ? 16'hAAAA : 16'h0000)) begin
                n_fail++; $display("FAIL clip idx=%0d got %h want %h", idx_t[k], pixel_data,
                                   (k < 6 || k == 7) ? 16'hAAAA : 16'h0000);
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            idle(2);
            for (int s = 0; s < N; s++)
                for (int a = 0; a < 256; a++)
                    rom[s][a] = ($urandom_range(0, 3) == 0) ? TR : 16'($urandom);
            for (int s = 0; s < N; s++)
                step(OOR, 0, 1, s, int'($urandom_range(0, 60)), int'($urandom_range(0, 50)),
                     bit'($urandom_range(0, 4) != 0), bit'($urandom_range(0, 1)));
            step(OOR, 1);
            for (int i = 0; i < 1500; i++) begin
                step(int'($urandom_range(0, 6300)), bit'($urandom_range(0, 199) == 0),
                     bit'($urandom_range(0, 49) == 0), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 127)), int'($urandom_range(0, 63)),
                     bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
                n_checks++;
                if (pixel_data !== exp_pix || collide !== exp_col) begin
                    n_fail++; $display("FAIL random r=%0d i=%0d got %h/%b want %h/%b",
                                       round, i, pixel_data, collide, exp_pix, exp_col);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; frame_begin = 1'b0; pixel_index = '0; wr_en = 1'b0;
        wr_sel = '0; wr_x = '0; wr_y = '0; wr_vis = 1'b0; wr_flip = 1'b0;
        test_reset();
        test_blank_sweep();
        test_single_sprite();
        test_collision();
        test_double_buffer();
        test_flip_transparency();
        test_clip_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
